// File: rtl/i_memory_pkg.sv
// Shared datapath constants for the LEGv8 storage blocks (data memory,
// register file, instruction memory).
package i_memory_pkg;

    localparam int WORD      = 64;
    localparam int DEPTH     = 32;
    localparam int ADDR_BITS = $clog2(DEPTH);

    typedef logic [WORD-1:0] word_t;

endpackage

// File: rtl/i_memory_if.sv
// Data-memory bus: ALU address/data in, read data and branch select out.
interface i_memory_if;
    import i_memory_pkg::*;

    word_t address;
    word_t write_data;
    logic  mem_read;
    logic  mem_write;
    logic  zero;
    logic  branch;
    logic  uncondbranch;
    word_t read_data;
    logic  pc_src;

    modport master (
        output address, write_data, mem_read, mem_write,
               zero, branch, uncondbranch,
        input  read_data, pc_src
    );

    modport slave (
        input  address, write_data, mem_read, mem_write,
               zero, branch, uncondbranch,
        output read_data, pc_src
    );

endinterface

// File: rtl/i_memory_branch_ctrl.sv
// PC-source select: take the branch target on B, or on CBZ with a zero result.
module i_memory_branch_ctrl (
    input  logic zero_i,
    input  logic branch_i,
    input  logic uncondbranch_i,
    output logic pc_src_o
);

    assign pc_src_o = uncondbranch_i | (branch_i & zero_i);

endmodule

// File: rtl/i_memory.sv
// LEGv8 data-memory stage: word-indexed RAM with combinational read, clocked
// write, and the branch PC-source select.
module i_memory
    import i_memory_pkg::*;
#(
    parameter int MEM_DEPTH = DEPTH,
    parameter int IDX_BITS  = ADDR_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    i_memory_if.slave     bus
);

    word_t                mem_q [MEM_DEPTH];
    word_t                mem_d [MEM_DEPTH];
    logic  [IDX_BITS-1:0] idx;
    logic                 unused_addr_hi;

    // Upper address bits are deliberately dropped so addresses wrap.
    assign idx            = bus.address[IDX_BITS-1:0];
    assign unused_addr_hi = ^bus.address[WORD-1:IDX_BITS];

    always_comb begin
        mem_d = mem_q;
        if (bus.mem_write) begin
            mem_d[idx] = bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                mem_q[k] <= WORD'(k);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign bus.read_data = bus.mem_read ? mem_q[idx] : '0;

    i_memory_branch_ctrl u_branch_ctrl (
        .zero_i         (bus.zero),
        .branch_i       (bus.branch),
        .uncondbranch_i (bus.uncondbranch),
        .pc_src_o       (bus.pc_src)
    );

endmodule

// File: tb/tb_i_memory.sv
// Bench for i_memory: directed sequences, branch truth table, randomized run
// against an array model of the memory.
module tb_i_memory;
    import i_memory_pkg::*;

    typedef struct {
        logic branch;
        logic zero;
        logic uncond;
        logic exp_pc_src;
    } br_vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [63:0] model [32];
    br_vec_t     tbl [8];

    i_memory_if bus ();

    i_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) model[k] = 64'(k);
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] addr, input logic rd);
        return rd ? model[addr % 64'd32] : 64'd0;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        rst_n            = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.zero         = 1'b0;
        bus.branch       = 1'b0;
        bus.uncondbranch = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset contents and wrap-around
        bus.mem_read = 1'b1;
        bus.address  = 64'd0;  #1; check("rst_addr0", bus.read_data, 64'd0);
        bus.address  = 64'd3;  #1; check("rst_addr3", bus.read_data, 64'd3);
        bus.address  = 64'd35; #1; check("rst_wrap35", bus.read_data, 64'd3);

        // Write then read back
        @(negedge clk);
        bus.address = 64'd3; bus.write_data = 64'd100; bus.mem_write = 1'b1;
        @(posedge clk); #1;
        check("wr100_after_edge", bus.read_data, 64'd100);
        @(negedge clk);
        bus.mem_write = 1'b0; #1;
        check("wr100_hold", bus.read_data, 64'd100);
        bus.address = 64'd4; #1;
        check("addr4_untouched", bus.read_data, 64'd4);

        // Read disabled gives zero
        bus.mem_read = 1'b0;
        bus.address = 64'd3; #1; check("rd_dis_a3", bus.read_data, 64'd0);
        bus.address = 64'd17; #1; check("rd_dis_a17", bus.read_data, 64'd0);

        // Edge with write disabled leaves contents alone
        @(negedge clk);
        bus.address = 64'd3; bus.write_data = 64'd55; bus.mem_read = 1'b1;
        @(posedge clk); #1;
        check("wr_dis_hold", bus.read_data, 64'd100);

        // Async reset between edges; write pending during reset is dropped
        @(negedge clk);
        bus.mem_write = 1'b1; bus.write_data = 64'd77;
        rst_n = 1'b0; #1;
        check("async_rst_a3", bus.read_data, 64'd3);
        @(posedge clk); #1;
        check("rst_blocks_write", bus.read_data, 64'd3);
        @(negedge clk);
        bus.mem_write = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Simultaneous read and write: old value before edge, new after
        @(negedge clk);
        bus.address = 64'd7; bus.write_data = '1; bus.mem_read = 1'b1; bus.mem_write = 1'b1; #1;
        check("rw_before_edge", bus.read_data, 64'd7);
        @(posedge clk); #1;
        check("rw_after_edge", bus.read_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        bus.mem_write = 1'b0;
        model[7] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Branch truth table
        for (int i = 0; i < 8; i++) begin
            bus.branch = tbl[i].branch; bus.zero = tbl[i].zero; bus.uncondbranch = tbl[i].uncond;
            #1;
            check($sformatf("pc_src_b%0b_z%0b_u%0b", tbl[i].branch, tbl[i].zero, tbl[i].uncond),
                  {63'd0, bus.pc_src}, {63'd0, tbl[i].exp_pc_src});
        end

        // Randomized run against the array model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            logic [63:0] wd;
            logic        rd;
            logic        wr;
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                bus.mem_read = 1'b1;
                bus.address  = 64'($urandom_range(0, 31));
                #1;
                check("rand_async_rst", bus.read_data, model_read(bus.address, 1'b1));
                rst_n = 1'b1;
            end
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            rd = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 1) == 1);
            bus.address = a; bus.write_data = wd; bus.mem_read = rd; bus.mem_write = wr;
            bus.branch = 1'($urandom); bus.zero = 1'($urandom); bus.uncondbranch = 1'($urandom);
            #1;
            check("rand_rd_pre", bus.read_data, model_read(a, rd));
            check("rand_pc_src", {63'd0, bus.pc_src},
                  {63'd0, (bus.uncondbranch || (bus.branch && bus.zero))});
            @(posedge clk); #1;
            if (wr) model[a % 64'd32] = wd;
            check("rand_rd_post", bus.read_data, model_read(a, rd));
        end

        // Full sweep of final contents
        @(negedge clk);
        bus.mem_write = 1'b0; bus.mem_read = 1'b1;
        for (int k = 0; k < 32; k++) begin
            bus.address = 64'(k) + 64'd32 * 64'($urandom_range(0, 1000));
            #1;
            check($sformatf("sweep_%0d", k), bus.read_data, model[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
